// File: rtl/particle_ctl_pkg.sv
// Shared types and geometry for the particle throw controller and its peers.
// Player encoding, sprite/target box sizes and the box-overlap helper live here.
package particle_ctl_pkg;

    typedef enum logic [1:0] {IDLE, FLIGHT, IMPACT} particle_state_t;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    localparam int PARTICLE_WIDTH  = 16;
    localparam int PARTICLE_HEIGHT = 16;
    localparam int TARGET_W        = 64;
    localparam int TARGET_H        = 64;
    localparam int GRAVITY_DEFAULT = 1;

    localparam logic signed [13:0] PW14 = 14'(PARTICLE_WIDTH);
    localparam logic signed [13:0] PH14 = 14'(PARTICLE_HEIGHT);
    localparam logic signed [13:0] TW14 = 14'(TARGET_W);
    localparam logic signed [13:0] TH14 = 14'(TARGET_H);

    // Widened to 14 bits so target_x + TARGET_W cannot wrap.
    function automatic logic box_overlap(input logic signed [13:0] px,
                                         input logic signed [13:0] py,
                                         input logic signed [13:0] tx,
                                         input logic signed [13:0] ty);
        return (px < tx + TW14) && (px + PW14 > tx) &&
               (py < ty + TH14) && (py + PH14 > ty);
    endfunction

endpackage

// File: rtl/particle_ctl_if.sv
// Game-logic <-> particle controller bus; master = game side, slave = controller.
// PARTICLE_WIND_EN adds the signed wind input.
interface particle_ctl_if;
    logic        vblnk;
    logic        throw;
    logic        turn;
    logic [5:0]  vx_init;
    logic [5:0]  vy_init;
    logic [11:0] target_x;
    logic [11:0] target_y;
`ifdef PARTICLE_WIND_EN
    logic signed [3:0] wind;
`endif
    logic [11:0] xpos_particle;
    logic [11:0] ypos_particle;
    logic        particle_active;
    logic        hit;
    logic        throw_done;

    modport master (
        output vblnk, throw, turn, vx_init, vy_init, target_x, target_y,
`ifdef PARTICLE_WIND_EN
        output wind,
`endif
        input  xpos_particle, ypos_particle, particle_active, hit, throw_done
    );

    modport slave (
        input  vblnk, throw, turn, vx_init, vy_init, target_x, target_y,
`ifdef PARTICLE_WIND_EN
        input  wind,
`endif
        output xpos_particle, ypos_particle, particle_active, hit, throw_done
    );
endinterface

// File: rtl/particle_ctl_frame_tick_gen.sv
// Rising-edge detector on vblnk: one-clock frame tick, combinational from vblnk.
// Latency 0 cycles from vblnk rise; no backpressure.
module frame_tick_gen (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vblnk,
    output logic o_tick
);
    logic r_vblnk_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_vblnk_q <= 1'b0;
        else       r_vblnk_q <= i_vblnk;
    end

    assign o_tick = i_vblnk & ~r_vblnk_q;
endmodule

// File: rtl/particle_ctl.sv
// Throw controller: launches on throw in IDLE, steps trajectory once per frame, holds impact, pulses throw_done.
// Outputs registered (1 clk after launch/tick); throw ignored outside IDLE. Optional PARTICLE_WIND_EN.
module particle_ctl
    import particle_ctl_pkg::*;
#(
    parameter int P1_X          = 100,
    parameter int P1_Y          = 500,
    parameter int P2_X          = 900,
    parameter int P2_Y          = 500,
    parameter int GROUND_Y      = 520,
    parameter int SCREEN_W      = 1024,
    parameter int GRAVITY       = GRAVITY_DEFAULT,
    parameter int IMPACT_FRAMES = 30,
    parameter int PARK_POS      = 4095
) (
    input  logic          clk60MHz,
    input  logic          rst,
    particle_ctl_if.slave bus
);
    localparam logic signed [12:0] PARK   = 13'(PARK_POS);
    localparam logic signed [12:0] GROUND = 13'(GROUND_Y);
    localparam logic signed [12:0] X_MAX  = 13'(SCREEN_W - PARTICLE_WIDTH);
    localparam logic signed [12:0] VY_MAX = 13'sd2047;
    localparam logic signed [12:0] G13    = 13'(GRAVITY);
    localparam logic [7:0]         CNT_END = 8'(IMPACT_FRAMES - 1);

    particle_state_t   r_state;
    logic              r_dir;
    logic signed [12:0] r_x, r_y, r_vx, r_vy;
    logic [7:0]        r_cnt;
    logic              r_active, r_hit, r_done;

    logic              w_tick;
    logic signed [12:0] w_x_n, w_y_n, w_vy_n;
    logic              w_hit, w_ground, w_out;

    frame_tick_gen u_tick (
        .i_clk   (clk60MHz),
        .i_rst   (rst),
        .i_vblnk (bus.vblnk),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_x_n = (r_dir == PLAYER_1) ? r_x + r_vx : r_x - r_vx;
`ifdef PARTICLE_WIND_EN
        w_x_n = w_x_n + {{9{bus.wind[3]}}, bus.wind};
`endif
        w_y_n  = r_y + r_vy;
        w_vy_n = (r_vy > VY_MAX - G13) ? VY_MAX : r_vy + G13;
        w_hit  = box_overlap({w_x_n[12], w_x_n}, {w_y_n[12], w_y_n},
                             {2'b00, bus.target_x}, {2'b00, bus.target_y});
        w_ground = (w_y_n >= GROUND);
        w_out    = (w_x_n < 13'sd0) || (w_x_n > X_MAX) || (w_y_n < 13'sd0);
    end

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dir    <= PLAYER_1;
            r_x      <= PARK;
            r_y      <= PARK;
            r_vx     <= '0;
            r_vy     <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_hit    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.throw) begin
                        r_dir    <= bus.turn;
                        r_x      <= (bus.turn == PLAYER_1) ? 13'(P1_X) : 13'(P2_X);
                        r_y      <= (bus.turn == PLAYER_1) ? 13'(P1_Y) : 13'(P2_Y);
                        r_vx     <= {7'b0, bus.vx_init};
                        r_vy     <= 13'sd0 - $signed({7'b0, bus.vy_init});
                        r_hit    <= 1'b0;
                        r_active <= 1'b1;
                        r_state  <= FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (w_tick) begin
                        r_vy <= w_vy_n;
                        if (w_hit) begin
                            r_x   <= w_x_n;
                            r_y   <= w_y_n;
                            r_hit <= 1'b1;
                        end else if (w_ground) begin
                            r_x <= w_x_n;
                            r_y <= GROUND;
                        end else if (w_out) begin
                            r_x <= PARK;
                            r_y <= PARK;
                        end else begin
                            r_x <= w_x_n;
                            r_y <= w_y_n;
                        end
                        if (w_hit || w_ground || w_out) begin
                            r_cnt   <= '0;
                            r_state <= IMPACT;
                        end
                    end
                end
                IMPACT: begin
                    if (w_tick) begin
                        if (r_cnt == CNT_END) begin
                            r_x      <= PARK;
                            r_y      <= PARK;
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.xpos_particle   = r_x[11:0];
    assign bus.ypos_particle   = r_y[11:0];
    assign bus.particle_active = r_active;
    assign bus.hit             = r_hit;
    assign bus.throw_done      = r_done;
endmodule

// File: tb/tb_particle_ctl.sv
// Directed bench for particle_ctl: reset, ground landing, target hit, edge exit, reset mid-flight.
module tb_particle_ctl;
    import particle_ctl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   done_seen = 0;

    always #8 clk = ~clk;

    particle_ctl_if bus();

    particle_ctl dut (
        .clk60MHz (clk),
        .rst      (rst),
        .bus      (bus)
    );

    task automatic cyc();
        @(negedge clk);
        if (bus.throw_done === 1'b1) done_seen++;
    endtask

    task automatic frame();
        bus.vblnk = 1'b1; cyc(); cyc();
        bus.vblnk = 1'b0; cyc(); cyc();
    endtask

    task automatic launch(input logic t, input logic [5:0] vx, input logic [5:0] vy,
                          input logic [11:0] tx, input logic [11:0] ty);
        bus.turn = t; bus.vx_init = vx; bus.vy_init = vy;
        bus.target_x = tx; bus.target_y = ty;
        bus.throw = 1'b1; cyc();
        bus.throw = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.vblnk = 1'b0; bus.throw = 1'b0; bus.turn = PLAYER_1;
        bus.vx_init = '0; bus.vy_init = '0; bus.target_x = '0; bus.target_y = '0;
`ifdef PARTICLE_WIND_EN
        bus.wind = '0;
`endif
        cyc(); cyc(); cyc();
        rst = 1'b0; cyc();
        n_tests++;
        if (bus.xpos_particle !== 12'd4095 || bus.ypos_particle !== 12'd4095 ||
            bus.particle_active !== 1'b0 || bus.hit !== 1'b0 || bus.throw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals x=%0d y=%0d act=%b hit=%b done=%b want 4095,4095,0,0,0",
                     bus.xpos_particle, bus.ypos_particle, bus.particle_active, bus.hit, bus.throw_done);
        end
        done_seen = 0;
        for (int i = 0; i < 5; i++) frame();
        n_tests++;
        if (bus.xpos_particle !== 12'd4095 || bus.ypos_particle !== 12'd4095 ||
            bus.particle_active !== 1'b0 || done_seen !== 0) begin
            n_fail++;
            $display("FAIL idle_frames x=%0d y=%0d act=%b dones=%0d want 4095,4095,0,0",
                     bus.xpos_particle, bus.ypos_particle, bus.particle_active, done_seen);
        end
    endtask

    task automatic test_ground();
        done_seen = 0;
        launch(PLAYER_1, 6'd4, 6'd10, 12'd4000, 12'd4000);
        n_tests++;
        if (bus.xpos_particle !== 12'd100 || bus.ypos_particle !== 12'd500 || bus.particle_active !== 1'b1) begin
            n_fail++;
            $display("FAIL gnd_launch x=%0d y=%0d act=%b want 100,500,1",
                     bus.xpos_particle, bus.ypos_particle, bus.particle_active);
        end
        for (int f = 1; f <= 23; f++) begin
            frame();
            case (f)
                1: begin
                    n_tests++;
                    if (bus.xpos_particle !== 12'd104 || bus.ypos_particle !== 12'd490) begin
                        n_fail++;
                        $display("FAIL gnd_f1 x=%0d y=%0d want 104,490", bus.xpos_particle, bus.ypos_particle);
                    end
                end
                10: begin
                    n_tests++;
                    if (bus.xpos_particle !== 12'd140 || bus.ypos_particle !== 12'd445) begin
                        n_fail++;
                        $display("FAIL gnd_f10 x=%0d y=%0d want 140,445", bus.xpos_particle, bus.ypos_particle);
                    end
                end
                21: begin
                    n_tests++;
                    if (bus.xpos_particle !== 12'd184 || bus.ypos_particle !== 12'd500) begin
                        n_fail++;
                        $display("FAIL gnd_f21 x=%0d y=%0d want 184,500", bus.xpos_particle, bus.ypos_particle);
                    end
                end
                23: begin
                    n_tests++;
                    if (bus.xpos_particle !== 12'd192 || bus.ypos_particle !== 12'd520 || bus.particle_active !== 1'b1) begin
                        n_fail++;
                        $display("FAIL gnd_f23 x=%0d y=%0d act=%b want 192,520,1",
                                 bus.xpos_particle, bus.ypos_particle, bus.particle_active);
                    end
                end
                default: ;
            endcase
        end
        for (int i = 0; i < 29; i++) frame();
        n_tests++;
        if (done_seen !== 0 || bus.particle_active !== 1'b1 ||
            bus.xpos_particle !== 12'd192 || bus.ypos_particle !== 12'd520) begin
            n_fail++;
            $display("FAIL gnd_hold dones=%0d act=%b x=%0d y=%0d want 0,1,192,520",
                     done_seen, bus.particle_active, bus.xpos_particle, bus.ypos_particle);
        end
        frame();
        n_tests++;
        if (done_seen !== 1 || bus.particle_active !== 1'b0 || bus.hit !== 1'b0 ||
            bus.xpos_particle !== 12'd4095 || bus.ypos_particle !== 12'd4095) begin
            n_fail++;
            $display("FAIL gnd_done dones=%0d act=%b hit=%b x=%0d y=%0d want 1,0,0,4095,4095",
                     done_seen, bus.particle_active, bus.hit, bus.xpos_particle, bus.ypos_particle);
        end
    endtask

    task automatic test_target_hit();
        done_seen = 0;
        launch(PLAYER_2, 6'd4, 6'd10, 12'd800, 12'd440);
        for (int i = 0; i < 9; i++) frame();
        n_tests++;
        if (bus.xpos_particle !== 12'd864 || bus.ypos_particle !== 12'd446 || bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_f9 x=%0d y=%0d hit=%b want 864,446,0",
                     bus.xpos_particle, bus.ypos_particle, bus.hit);
        end
        frame();
        n_tests++;
        if (bus.xpos_particle !== 12'd860 || bus.ypos_particle !== 12'd445 || bus.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_f10 x=%0d y=%0d hit=%b want 860,445,1",
                     bus.xpos_particle, bus.ypos_particle, bus.hit);
        end
        frame();
        n_tests++;
        if (bus.xpos_particle !== 12'd860 || bus.ypos_particle !== 12'd445 || bus.particle_active !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_frozen x=%0d y=%0d act=%b want 860,445,1",
                     bus.xpos_particle, bus.ypos_particle, bus.particle_active);
        end
        for (int i = 0; i < 28; i++) frame();
        n_tests++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("FAIL hit_early_done dones=%0d want 0", done_seen);
        end
        frame();
        n_tests++;
        if (done_seen !== 1 || bus.hit !== 1'b1 || bus.particle_active !== 1'b0 ||
            bus.xpos_particle !== 12'd4095) begin
            n_fail++;
            $display("FAIL hit_done dones=%0d hit=%b act=%b x=%0d want 1,1,0,4095",
                     done_seen, bus.hit, bus.particle_active, bus.xpos_particle);
        end
    endtask

    task automatic test_left_exit();
        done_seen = 0;
        launch(PLAYER_2, 6'd63, 6'd7, 12'd4000, 12'd4000);
        n_tests++;
        if (bus.hit !== 1'b0 || bus.xpos_particle !== 12'd900) begin
            n_fail++;
            $display("FAIL exit_launch hit=%b x=%0d want 0,900", bus.hit, bus.xpos_particle);
        end
        for (int i = 0; i < 14; i++) frame();
        n_tests++;
        if (bus.xpos_particle !== 12'd18 || bus.ypos_particle !== 12'd493) begin
            n_fail++;
            $display("FAIL exit_f14 x=%0d y=%0d want 18,493", bus.xpos_particle, bus.ypos_particle);
        end
        frame();
        n_tests++;
        if (bus.xpos_particle !== 12'd4095 || bus.ypos_particle !== 12'd4095 || bus.particle_active !== 1'b1) begin
            n_fail++;
            $display("FAIL exit_f15 x=%0d y=%0d act=%b want 4095,4095,1",
                     bus.xpos_particle, bus.ypos_particle, bus.particle_active);
        end
        for (int i = 0; i < 30; i++) frame();
        n_tests++;
        if (done_seen !== 1 || bus.hit !== 1'b0 || bus.particle_active !== 1'b0) begin
            n_fail++;
            $display("FAIL exit_done dones=%0d hit=%b act=%b want 1,0,0", done_seen, bus.hit, bus.particle_active);
        end
    endtask

    task automatic test_back_to_back();
        done_seen = 0;
        bus.turn = PLAYER_1; bus.vx_init = 6'd4; bus.vy_init = 6'd10;
        bus.target_x = 12'd4000; bus.target_y = 12'd4000;
        bus.throw = 1'b1; bus.vblnk = 1'b1; cyc();
        bus.throw = 1'b0; cyc();
        bus.vblnk = 1'b0; cyc(); cyc();
        n_tests++;
        if (bus.xpos_particle !== 12'd100 || bus.ypos_particle !== 12'd500) begin
            n_fail++;
            $display("FAIL same_tick_launch x=%0d y=%0d want 100,500", bus.xpos_particle, bus.ypos_particle);
        end
        frame();
        n_tests++;
        if (bus.xpos_particle !== 12'd104 || bus.ypos_particle !== 12'd490) begin
            n_fail++;
            $display("FAIL same_tick_f1 x=%0d y=%0d want 104,490", bus.xpos_particle, bus.ypos_particle);
        end
        bus.throw = 1'b1;
        frame(); frame();
        bus.throw = 1'b0;
        n_tests++;
        if (bus.xpos_particle !== 12'd112 || bus.ypos_particle !== 12'd473) begin
            n_fail++;
            $display("FAIL throw_ignored x=%0d y=%0d want 112,473", bus.xpos_particle, bus.ypos_particle);
        end
        frame();
        n_tests++;
        if (bus.xpos_particle !== 12'd116 || bus.ypos_particle !== 12'd466) begin
            n_fail++;
            $display("FAIL pre_rst_f4 x=%0d y=%0d want 116,466", bus.xpos_particle, bus.ypos_particle);
        end
        bus.vblnk = 1'b1; rst = 1'b1; cyc();
        rst = 1'b0; cyc();
        bus.vblnk = 1'b0; cyc(); cyc();
        n_tests++;
        if (bus.xpos_particle !== 12'd4095 || bus.ypos_particle !== 12'd4095 ||
            bus.particle_active !== 1'b0 || bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst x=%0d y=%0d act=%b hit=%b want 4095,4095,0,0",
                     bus.xpos_particle, bus.ypos_particle, bus.particle_active, bus.hit);
        end
        for (int i = 0; i < 40; i++) frame();
        n_tests++;
        if (done_seen !== 0 || bus.xpos_particle !== 12'd4095 || bus.particle_active !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_done dones=%0d x=%0d act=%b want 0,4095,0",
                     done_seen, bus.xpos_particle, bus.particle_active);
        end
    endtask

`ifdef PARTICLE_WIND_EN
    task automatic test_wind();
        bus.wind = -4'sd2;
        launch(PLAYER_1, 6'd4, 6'd10, 12'd4000, 12'd4000);
        frame();
        n_tests++;
        if (bus.xpos_particle !== 12'd102 || bus.ypos_particle !== 12'd490) begin
            n_fail++;
            $display("FAIL wind_f1 x=%0d y=%0d want 102,490", bus.xpos_particle, bus.ypos_particle);
        end
        frame();
        n_tests++;
        if (bus.xpos_particle !== 12'd104) begin
            n_fail++;
            $display("FAIL wind_f2 x=%0d want 104", bus.xpos_particle);
        end
        rst = 1'b1; cyc(); rst = 1'b0; bus.wind = '0; cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_ground();
        test_target_hit();
        test_left_exit();
        test_back_to_back();
`ifdef PARTICLE_WIND_EN
        test_wind();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
